// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage behind execute. It runs loads and stores over a req/ack
// data-memory port, aligns and extends load data, and hands the writeback bundle to the
// register-file stage over valid/ready.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned half/word accesses
// skip memory and report through the misalign port.
module mem_access_stage #(
   parameter int DW  = 32,
   parameter int IW  = 32,
   parameter int RFW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IW-1:0]     inst,
   input  logic [DW-1:0]     alu_res,
   input  logic [DW-1:0]     store_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DW-1:0]     dmem_addr,
   output logic [DW/8-1:0]   dmem_be,
   output logic [DW-1:0]     dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DW-1:0]     dmem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [RFW-1:0]    out_rd,
   output logic              out_we
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misalign
`endif
);

   localparam int BW = DW / 8;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             dmem_req_q, dmem_req_d;
   logic             dmem_we_q, dmem_we_d;
   logic [DW-1:0]    dmem_addr_q, dmem_addr_d;
   logic [BW-1:0]    dmem_be_q, dmem_be_d;
   logic [DW-1:0]    dmem_wdata_q, dmem_wdata_d;
   logic             out_valid_q, out_valid_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [RFW-1:0]   out_rd_q, out_rd_d;
   logic             out_we_q, out_we_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       lane_q, lane_d;
   logic             is_load_q, is_load_d;
`ifdef MISALIGN_TRAP_EN
   logic             misalign_q, misalign_d;
`endif

   logic [4:0]       opc_s;
   logic [2:0]       f3_s;
   logic [RFW-1:0]   rd_s;
   logic             load_ok_s, store_ok_s, mem_ok_s, writes_rd_s, misaligned_s;
   logic [BW-1:0]    be_s;
   logic [DW-1:0]    wdata_s;
   logic             unused_inst_s;

   assign unused_inst_s = ^{inst[IW-1:15], inst[1:0]};

   // Pick the addressed byte/half out of the read word and sign/zero extend it.
   function automatic logic [DW-1:0] align_load(input logic [DW-1:0] word,
                                                input logic [2:0]    f3,
                                                input logic [1:0]    lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  align_load = {{(DW-8){b[7]}}, b};
         3'b100:  align_load = {{(DW-8){1'b0}}, b};
         3'b001:  align_load = {{(DW-16){h[15]}}, h};
         3'b101:  align_load = {{(DW-16){1'b0}}, h};
         default: align_load = word;
      endcase
   endfunction

   // Decode the incoming instruction: legality, register write class and store lane setup.
   always_comb begin
      opc_s        = inst[6:2];
      f3_s         = inst[14:12];
      rd_s         = inst[11:7];
      load_ok_s    = (opc_s == OPC_LOAD) &&
                     ((f3_s == 3'b000) || (f3_s == 3'b001) || (f3_s == 3'b010) ||
                      (f3_s == 3'b100) || (f3_s == 3'b101));
      store_ok_s   = (opc_s == OPC_STORE) &&
                     ((f3_s == 3'b000) || (f3_s == 3'b001) || (f3_s == 3'b010));
      writes_rd_s  = (opc_s == OPC_OP) || (opc_s == OPC_OP_IMM) || (opc_s == OPC_LUI) ||
                     (opc_s == OPC_AUIPC) || (opc_s == OPC_JAL) || (opc_s == OPC_JALR);
      misaligned_s = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (f3_s[1:0] == 2'b01) begin
         misaligned_s = alu_res[0];
      end else if (f3_s[1:0] == 2'b10) begin
         misaligned_s = (alu_res[1:0] != 2'b00);
      end else begin
         misaligned_s = 1'b0;
      end
`endif
      mem_ok_s = (load_ok_s || store_ok_s) && !misaligned_s;
      case (f3_s[1:0])
         2'b00: begin
            be_s    = {{(BW-1){1'b0}}, 1'b1} << alu_res[1:0];
            wdata_s = {BW{store_data[7:0]}};
         end
         2'b01: begin
            be_s    = {{(BW-2){1'b0}}, 2'b11} << {alu_res[1], 1'b0};
            wdata_s = {(DW/16){store_data[15:0]}};
         end
         default: begin
            be_s    = {BW{1'b1}};
            wdata_s = store_data;
         end
      endcase
   end

   // Next-state and next-output logic for the IDLE -> ACCESS -> RESP handshake FSM.
   always_comb begin
      state_d      = state_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_rd_d     = out_rd_q;
      out_we_d     = out_we_q;
      f3_d         = f3_q;
      lane_d       = lane_q;
      is_load_d    = is_load_q;
`ifdef MISALIGN_TRAP_EN
      misalign_d   = misalign_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               out_rd_d   = rd_s;
               out_data_d = alu_res;
               f3_d       = f3_s;
               lane_d     = alu_res[1:0];
               is_load_d  = load_ok_s;
               if (mem_ok_s) begin
                  state_d     = ST_ACCESS;
                  dmem_req_d  = 1'b1;
                  dmem_we_d   = store_ok_s;
                  dmem_addr_d = {alu_res[DW-1:2], 2'b00};
                  if (store_ok_s) begin
                     dmem_be_d    = be_s;
                     dmem_wdata_d = wdata_s;
                  end else begin
                     dmem_be_d    = {BW{1'b0}};
                  end
               end else begin
                  // Non-memory, illegal or trapped access: answer straight away.
                  state_d     = ST_RESP;
                  out_valid_d = 1'b1;
                  out_we_d    = writes_rd_s && (rd_s != {RFW{1'b0}});
`ifdef MISALIGN_TRAP_EN
                  misalign_d  = misaligned_s;
`endif
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               state_d     = ST_RESP;
               dmem_req_d  = 1'b0;
               dmem_we_d   = 1'b0;
               dmem_be_d   = {BW{1'b0}};
               out_valid_d = 1'b1;
               if (is_load_q) begin
                  out_data_d = align_load(dmem_rdata, f3_q, lane_q);
                  out_we_d   = (out_rd_q != {RFW{1'b0}});
               end else begin
                  out_we_d   = 1'b0;
               end
            end else begin
               state_d = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               out_we_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
               misalign_d  = 1'b0;
`endif
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         in_ready_q   <= 1'b1;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= {DW{1'b0}};
         dmem_be_q    <= {BW{1'b0}};
         dmem_wdata_q <= {DW{1'b0}};
         out_valid_q  <= 1'b0;
         out_data_q   <= {DW{1'b0}};
         out_rd_q     <= {RFW{1'b0}};
         out_we_q     <= 1'b0;
         f3_q         <= 3'b000;
         lane_q       <= 2'b00;
         is_load_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_rd_q     <= out_rd_d;
         out_we_q     <= out_we_d;
         f3_q         <= f3_d;
         lane_q       <= lane_d;
         is_load_q    <= is_load_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q   <= misalign_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_rd     = out_rd_q;
   assign out_we     = out_we_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign   = misalign_q;
`endif

endmodule
